// File: rtl/uart_pkg.sv
// Shared UART definitions: arbiter FSM encodings, header tag and baud defaults
// used by the receiver, the baud_tick generator and the TX arbiter.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ISSUE     = 3'd1,
        WAIT_BUSY = 3'd2,
        WAIT_DONE = 3'd3,
        HDR       = 3'd4
    } arb_state_t;

    localparam logic [3:0] HDR_TAG = 4'hA;

    localparam int unsigned CLK_HZ          = 50_000_000;
    localparam int unsigned BAUD_RATE       = 115_200;
    localparam int unsigned BAUD_OVERSAMPLE = 16;
    localparam int unsigned BAUD_DIV        = CLK_HZ / BAUD_RATE;

    function automatic logic [7:0] hdr_byte(input logic [3:0] id);
        return {HDR_TAG, id};
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first asserted valid bit at or after ptr,
// wrapping modulo NREQ. ptr is expected to be below NREQ.
module rr_pick #(
    parameter int NREQ = 4,
    parameter int IDW  = 3
) (
    input  logic [NREQ-1:0] valid,
    input  logic [IDW-1:0]  ptr,
    output logic [IDW-1:0]  idx,
    output logic            found
);

    // Walk distances from farthest to nearest so the nearest hit wins.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            for (int j = 0; j < NREQ; j++) begin
                if (valid[j] && (j == ((int'(ptr) + k) % NREQ))) begin
                    idx   = IDW'(j);
                    found = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART TX core between NREQ byte streams,
// holding the grant for a whole req_last-delimited message. Define
// UART_ARB_ID_HDR_EN to prefix each message with an owner-ID header byte.
//
// state     | meaning
// IDLE      | no owner; arbitrate among req_valid from rr_ptr
// HDR       | send header byte for the new owner (UART_ARB_ID_HDR_EN only)
// ISSUE     | wait for owner byte and idle TX, then launch it
// WAIT_BUSY | wait for TX core to raise tx_busy
// WAIT_DONE | wait for tx_busy to fall; next byte or release grant
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [8*NREQ-1:0] req_data,
    input  logic [NREQ-1:0]   req_last,
    output logic [NREQ-1:0]   req_ready,
    output logic              tx_start,
    output logic [7:0]        tx_data,
    input  logic              tx_busy,
    output logic [IDW-1:0]    grant_id,
    output logic              grant_active
);

    arb_state_t     state, state_nxt;
    logic [IDW-1:0] rr_ptr;
    logic [IDW-1:0] rr_next;
    logic [IDW-1:0] pick_idx;
    logic           pick_found;
    logic           last_q;
    logic           owner_valid;
    logic           owner_last;
    logic [7:0]     owner_data;
    logic           accept;
    logic           done;

    rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick (
        .valid (req_valid),
        .ptr   (rr_ptr),
        .idx   (pick_idx),
        .found (pick_found)
    );

    always_comb begin
        owner_valid = 1'b0;
        owner_last  = 1'b0;
        owner_data  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_id == IDW'(i)) begin
                owner_valid = req_valid[i];
                owner_last  = req_last[i];
                owner_data  = req_data[8*i +: 8];
            end
        end
    end

    assign accept  = (state == ISSUE) && owner_valid && !tx_busy;
    assign done    = (state == WAIT_DONE) && !tx_busy;
    assign rr_next = (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + IDW'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (pick_found) begin
`ifdef UART_ARB_ID_HDR_EN
                    state_nxt = HDR;
`else
                    state_nxt = ISSUE;
`endif
                end
            end
`ifdef UART_ARB_ID_HDR_EN
            HDR:       if (!tx_busy) state_nxt = WAIT_BUSY;
`endif
            ISSUE:     if (accept)   state_nxt = WAIT_BUSY;
            WAIT_BUSY: if (tx_busy)  state_nxt = WAIT_DONE;
            WAIT_DONE: if (done)     state_nxt = last_q ? IDLE : ISSUE;
            default:   state_nxt = IDLE;
        endcase
    end

    always_comb begin
        tx_start  = 1'b0;
        tx_data   = '0;
        req_ready = '0;
        if (accept) begin
            tx_start = 1'b1;
            tx_data  = owner_data;
            for (int i = 0; i < NREQ; i++) begin
                req_ready[i] = (grant_id == IDW'(i));
            end
        end
`ifdef UART_ARB_ID_HDR_EN
        if ((state == HDR) && !tx_busy) begin
            tx_start = 1'b1;
            tx_data  = hdr_byte(4'(grant_id));
        end
`endif
    end

    // The header reuses WAIT_BUSY/WAIT_DONE; last_q=0 makes WAIT_DONE return to ISSUE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr       <= '0;
            grant_id     <= '0;
            grant_active <= 1'b0;
            last_q       <= 1'b0;
        end else begin
            if ((state == IDLE) && pick_found) begin
                grant_id     <= pick_idx;
                grant_active <= 1'b1;
            end
            if (accept) begin
                last_q <= owner_last;
            end
`ifdef UART_ARB_ID_HDR_EN
            if ((state == HDR) && !tx_busy) begin
                last_q <= 1'b0;
            end
`endif
            if (done && last_q) begin
                rr_ptr       <= rr_next;
                grant_active <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: lane drivers, a TX core model with
// randomized busy timing, and a message-level round-robin reference model.
module tb_uart_tx_arbiter;

    localparam int NREQ = 4;
    localparam int IDW  = 3;
`ifdef UART_ARB_ID_HDR_EN
    localparam bit HDR_EN = 1'b1;
`else
    localparam bit HDR_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NREQ-1:0]   req_valid = '0;
    logic [8*NREQ-1:0] req_data = '0;
    logic [NREQ-1:0]   req_last = '0;
    logic [NREQ-1:0]   req_ready;
    logic              tx_start;
    logic [7:0]        tx_data;
    logic              tx_busy = 1'b0;
    logic [IDW-1:0]    grant_id;
    logic              grant_active;

    uart_tx_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_last     (req_last),
        .req_ready    (req_ready),
        .tx_start     (tx_start),
        .tx_data      (tx_data),
        .tx_busy      (tx_busy),
        .grant_id     (grant_id),
        .grant_active (grant_active)
    );

    always #5 clk = ~clk;

    int tests_run = 0;
    int tests_failed = 0;

    byte unsigned q_data[NREQ][$];
    bit           q_last[NREQ][$];
    byte unsigned mq_data[NREQ][$];
    bit           mq_last[NREQ][$];
    byte unsigned tx_log[$];
    byte unsigned exp_log[$];
    int           stall_cnt[NREQ];
    int           rdy_cnt[NREQ];
    bit           rand_stall = 1'b0;
    int           busy_dly = 0;
    int           busy_len = 0;
    int           m_ptr = 0;

    // Lane drivers and TX core model update on the falling edge; outputs are
    // observed 1 time unit later, i.e. the values the next rising edge will act on.
    always @(negedge clk) begin
        if (rst) begin
            tx_busy   = 1'b0;
            busy_dly  = 0;
            busy_len  = 0;
            req_valid = '0;
        end else begin
            if (busy_dly > 0) begin
                busy_dly--;
                if (busy_dly == 0) tx_busy = 1'b1;
            end else if (tx_busy) begin
                busy_len--;
                if (busy_len <= 0) tx_busy = 1'b0;
            end
            for (int i = 0; i < NREQ; i++) begin
                req_valid[i] = (q_data[i].size() > 0) && (stall_cnt[i] == 0);
                if (stall_cnt[i] > 0) stall_cnt[i]--;
                req_data[8*i +: 8] = (q_data[i].size() > 0) ? q_data[i][0] : 8'($urandom);
                req_last[i] = (q_last[i].size() > 0) ? q_last[i][0] : 1'($urandom);
            end
            #1;
            if (!rst) begin
                if (tx_start) begin
                    tx_log.push_back(tx_data);
                    busy_dly = $urandom_range(1, 2);
                    busy_len = $urandom_range(2, 6);
                    if (req_ready == '0) begin
                        tests_run++;
                        if (!HDR_EN || tx_data[7:4] !== 4'hA) begin
                            tests_failed++;
                            $display("FAIL bare_tx_start tx_data=%02h with req_ready=0", tx_data);
                        end
                    end
                end
                if (req_ready != '0) begin
                    tests_run++;
                    if (!$onehot(req_ready) || !tx_start) begin
                        tests_failed++;
                        $display("FAIL ready_pulse req_ready=%b tx_start=%b want one-hot with tx_start=1",
                                 req_ready, tx_start);
                    end
                    for (int i = 0; i < NREQ; i++) begin
                        if (req_ready[i]) begin
                            tests_run++;
                            if (q_data[i].size() == 0 || tx_data !== q_data[i][0]) begin
                                tests_failed++;
                                $display("FAIL accept_data lane %0d tx_data=%02h want %02h", i, tx_data,
                                         (q_data[i].size() > 0) ? q_data[i][0] : 8'h00);
                            end
                            if (q_data[i].size() > 0) begin
                                if (rand_stall && !q_last[i][0]) stall_cnt[i] = $urandom_range(0, 4);
                                void'(q_data[i].pop_front());
                                void'(q_last[i].pop_front());
                            end
                            rdy_cnt[i]++;
                        end
                    end
                end
            end
        end
    end

    task automatic put(int lane, byte unsigned d, bit last, bit to_model);
        q_data[lane].push_back(d);
        q_last[lane].push_back(last);
        if (to_model) begin
            mq_data[lane].push_back(d);
            mq_last[lane].push_back(last);
        end
    endtask

    task automatic exp_hdr(int lane);
        if (HDR_EN) exp_log.push_back(8'hA0 | 8'(lane));
    endtask

    task automatic clear_logs();
        tx_log.delete();
        exp_log.delete();
        for (int i = 0; i < NREQ; i++) rdy_cnt[i] = 0;
    endtask

    task automatic clear_all();
        for (int i = 0; i < NREQ; i++) begin
            q_data[i].delete();
            q_last[i].delete();
            mq_data[i].delete();
            mq_last[i].delete();
            stall_cnt[i] = 0;
        end
        clear_logs();
        m_ptr = 0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        #3 rst = 1'b1;
        clear_all();
        @(negedge clk);
        @(negedge clk);
        #3 rst = 1'b0;
    endtask

    function automatic bit all_empty();
        for (int i = 0; i < NREQ; i++) begin
            if (q_data[i].size() != 0) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic wait_idle(string name);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            #2;
            n++;
        end while (n < 3000 && !(all_empty() && !grant_active && !tx_busy && busy_dly == 0));
        tests_run++;
        if (n >= 3000) begin
            tests_failed++;
            $display("FAIL %s_timeout still busy after %0d cycles", name, n);
        end
    endtask

    task automatic wait_rdy(int lane, int cnt, string name);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            #2;
            n++;
        end while (n < 500 && rdy_cnt[lane] < cnt);
        tests_run++;
        if (n >= 500) begin
            tests_failed++;
            $display("FAIL %s_wait lane %0d ready count %0d want %0d", name, lane, rdy_cnt[lane], cnt);
        end
    endtask

    // Message-level model: whole messages in round-robin order from m_ptr.
    task automatic model_round();
        int pick;
        int l;
        bit last;
        forever begin
            pick = -1;
            for (int k = 0; k < NREQ; k++) begin
                l = (m_ptr + k) % NREQ;
                if (pick < 0 && mq_data[l].size() > 0) pick = l;
            end
            if (pick < 0) break;
            exp_hdr(pick);
            do begin
                exp_log.push_back(mq_data[pick].pop_front());
                last = mq_last[pick].pop_front();
            end while (!last);
            m_ptr = (pick + 1) % NREQ;
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        #3 rst = 1'b1;
        clear_all();
        #2;
        tests_run += 5;
        if (req_ready !== '0)   begin tests_failed++; $display("FAIL reset_ready got %b want 0", req_ready); end
        if (tx_start !== 1'b0)  begin tests_failed++; $display("FAIL reset_start got %b want 0", tx_start); end
        if (tx_data !== 8'h00)  begin tests_failed++; $display("FAIL reset_data got %02h want 00", tx_data); end
        if (grant_id !== '0)    begin tests_failed++; $display("FAIL reset_gid got %0d want 0", grant_id); end
        if (grant_active !== 1'b0) begin tests_failed++; $display("FAIL reset_active got %b want 0", grant_active); end
        @(negedge clk);
        #3 rst = 1'b0;
    endtask

    task automatic test_single();
        apply_reset();
        put(0, 8'h55, 1'b0, 1'b0);
        put(0, 8'h3C, 1'b1, 1'b0);
        exp_hdr(0); exp_log.push_back(8'h55); exp_log.push_back(8'h3C);
        wait_idle("single");
        tests_run += 2;
        if (tx_log.size() != exp_log.size()) begin
            tests_failed++; $display("FAIL single_len got %0d want %0d", tx_log.size(), exp_log.size());
        end
        if (rdy_cnt[0] !== 2) begin
            tests_failed++; $display("FAIL single_ready got %0d want 2", rdy_cnt[0]);
        end
        foreach (exp_log[k]) begin
            tests_run++;
            if (k >= tx_log.size() || tx_log[k] !== exp_log[k]) begin
                tests_failed++; $display("FAIL single_byte[%0d] got %02h want %02h", k, tx_log[k], exp_log[k]);
            end
        end
        // rr_ptr should now be 1, so lane1 wins over lane0.
        clear_logs();
        put(0, 8'h20, 1'b1, 1'b0);
        put(1, 8'h21, 1'b1, 1'b0);
        exp_hdr(1); exp_log.push_back(8'h21); exp_hdr(0); exp_log.push_back(8'h20);
        wait_idle("ptr1");
        tests_run++;
        if (tx_log.size() != exp_log.size()) begin
            tests_failed++; $display("FAIL ptr1_len got %0d want %0d", tx_log.size(), exp_log.size());
        end
        foreach (exp_log[k]) begin
            tests_run++;
            if (k >= tx_log.size() || tx_log[k] !== exp_log[k]) begin
                tests_failed++; $display("FAIL ptr1_byte[%0d] got %02h want %02h", k, tx_log[k], exp_log[k]);
            end
        end
    endtask

    task automatic test_contention();
        apply_reset();
        for (int i = 0; i < NREQ; i++) begin
            put(i, 8'(8'h10 + i), 1'b1, 1'b0);
            exp_hdr(i);
            exp_log.push_back(8'(8'h10 + i));
        end
        wait_idle("contention");
        // rr_ptr wrapped back to 0: lane0 wins over lane3.
        put(3, 8'h23, 1'b1, 1'b0);
        put(0, 8'h20, 1'b1, 1'b0);
        exp_hdr(0); exp_log.push_back(8'h20); exp_hdr(3); exp_log.push_back(8'h23);
        wait_idle("contention_wrap");
        tests_run++;
        if (tx_log.size() != exp_log.size()) begin
            tests_failed++; $display("FAIL contention_len got %0d want %0d", tx_log.size(), exp_log.size());
        end
        foreach (exp_log[k]) begin
            tests_run++;
            if (k >= tx_log.size() || tx_log[k] !== exp_log[k]) begin
                tests_failed++; $display("FAIL contention_byte[%0d] got %02h want %02h", k, tx_log[k], exp_log[k]);
            end
        end
    endtask

    task automatic test_message_lock();
        clear_logs();
        put(2, 8'h30, 1'b0, 1'b0);
        put(2, 8'h31, 1'b0, 1'b0);
        put(2, 8'h32, 1'b1, 1'b0);
        wait_rdy(2, 1, "lock");
        put(1, 8'h40, 1'b1, 1'b0);
        exp_hdr(2); exp_log.push_back(8'h30); exp_log.push_back(8'h31); exp_log.push_back(8'h32);
        exp_hdr(1); exp_log.push_back(8'h40);
        wait_idle("lock");
        tests_run++;
        if (tx_log.size() != exp_log.size()) begin
            tests_failed++; $display("FAIL lock_len got %0d want %0d", tx_log.size(), exp_log.size());
        end
        foreach (exp_log[k]) begin
            tests_run++;
            if (k >= tx_log.size() || tx_log[k] !== exp_log[k]) begin
                tests_failed++; $display("FAIL lock_byte[%0d] got %02h want %02h", k, tx_log[k], exp_log[k]);
            end
        end
    endtask

    task automatic test_owner_stall();
        clear_logs();
        put(0, 8'h50, 1'b0, 1'b0);
        put(0, 8'h51, 1'b1, 1'b0);
        wait_rdy(0, 1, "stall");
        stall_cnt[0] = 20;
        put(3, 8'h53, 1'b1, 1'b0);
        for (int c = 0; c < 18; c++) begin
            @(negedge clk);
            #2;
            tests_run++;
            if (tx_start !== 1'b0 || grant_id !== 3'd0 || grant_active !== 1'b1 || req_ready !== '0) begin
                tests_failed++;
                $display("FAIL stall_hold cycle %0d start=%b gid=%0d active=%b ready=%b want 0/0/1/0",
                         c, tx_start, grant_id, grant_active, req_ready);
            end
        end
        exp_hdr(0); exp_log.push_back(8'h50); exp_log.push_back(8'h51);
        exp_hdr(3); exp_log.push_back(8'h53);
        wait_idle("stall");
        tests_run++;
        if (tx_log.size() != exp_log.size()) begin
            tests_failed++; $display("FAIL stall_len got %0d want %0d", tx_log.size(), exp_log.size());
        end
        foreach (exp_log[k]) begin
            tests_run++;
            if (k >= tx_log.size() || tx_log[k] !== exp_log[k]) begin
                tests_failed++; $display("FAIL stall_byte[%0d] got %02h want %02h", k, tx_log[k], exp_log[k]);
            end
        end
    endtask

    task automatic test_async_reset();
        int n;
        clear_logs();
        put(1, 8'h61, 1'b1, 1'b0);
        wait_idle("areset_pre");
        put(2, 8'h62, 1'b0, 1'b0);
        put(2, 8'h63, 1'b1, 1'b0);
        wait_rdy(2, 1, "areset");
        n = 0;
        while (n < 10 && !tx_busy) begin
            @(negedge clk);
            #2;
            n++;
        end
        @(negedge clk);
        #3 rst = 1'b1;
        #1;
        tests_run += 5;
        if (tx_start !== 1'b0)     begin tests_failed++; $display("FAIL areset_start got %b want 0", tx_start); end
        if (req_ready !== '0)      begin tests_failed++; $display("FAIL areset_ready got %b want 0", req_ready); end
        if (tx_data !== 8'h00)     begin tests_failed++; $display("FAIL areset_data got %02h want 00", tx_data); end
        if (grant_id !== '0)       begin tests_failed++; $display("FAIL areset_gid got %0d want 0", grant_id); end
        if (grant_active !== 1'b0) begin tests_failed++; $display("FAIL areset_active got %b want 0", grant_active); end
        clear_all();
        @(negedge clk);
        @(negedge clk);
        #3 rst = 1'b0;
        put(3, 8'h73, 1'b1, 1'b0);
        put(0, 8'h70, 1'b1, 1'b0);
        exp_hdr(0); exp_log.push_back(8'h70); exp_hdr(3); exp_log.push_back(8'h73);
        wait_idle("areset_post");
        tests_run++;
        if (tx_log.size() != exp_log.size()) begin
            tests_failed++; $display("FAIL areset_len got %0d want %0d", tx_log.size(), exp_log.size());
        end
        foreach (exp_log[k]) begin
            tests_run++;
            if (k >= tx_log.size() || tx_log[k] !== exp_log[k]) begin
                tests_failed++; $display("FAIL areset_byte[%0d] got %02h want %02h", k, tx_log[k], exp_log[k]);
            end
        end
    endtask

    task automatic test_random();
        int nmsg;
        int len;
        apply_reset();
        rand_stall = 1'b1;
        for (int r = 0; r < 6; r++) begin
            clear_logs();
            for (int i = 0; i < NREQ; i++) begin
                nmsg = $urandom_range(0, 2);
                for (int m = 0; m < nmsg; m++) begin
                    len = $urandom_range(1, 3);
                    for (int b = 0; b < len; b++) put(i, 8'($urandom), (b == len - 1), 1'b1);
                end
            end
            model_round();
            wait_idle("random");
            tests_run++;
            if (tx_log.size() != exp_log.size()) begin
                tests_failed++;
                $display("FAIL random_len round %0d got %0d want %0d", r, tx_log.size(), exp_log.size());
            end
            foreach (exp_log[k]) begin
                tests_run++;
                if (k >= tx_log.size() || tx_log[k] !== exp_log[k]) begin
                    tests_failed++;
                    $display("FAIL random_byte round %0d [%0d] got %02h want %02h", r, k, tx_log[k], exp_log[k]);
                end
            end
        end
        rand_stall = 1'b0;
    endtask

`ifdef UART_ARB_ID_HDR_EN
    task automatic test_header();
        apply_reset();
        put(3, 8'h7E, 1'b1, 1'b0);
        exp_log.push_back(8'hA3);
        exp_log.push_back(8'h7E);
        wait_idle("header");
        tests_run += 2;
        if (rdy_cnt[3] !== 1) begin
            tests_failed++; $display("FAIL header_ready got %0d want 1", rdy_cnt[3]);
        end
        if (tx_log.size() != exp_log.size()) begin
            tests_failed++; $display("FAIL header_len got %0d want %0d", tx_log.size(), exp_log.size());
        end
        foreach (exp_log[k]) begin
            tests_run++;
            if (k >= tx_log.size() || tx_log[k] !== exp_log[k]) begin
                tests_failed++; $display("FAIL header_byte[%0d] got %02h want %02h", k, tx_log[k], exp_log[k]);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_message_lock();
        test_owner_stall();
        test_async_reset();
        test_random();
`ifdef UART_ARB_ID_HDR_EN
        test_header();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Round-robin arbiter that shares one UART transmitter between NREQ byte-stream requesters.
- Grants one requester at a time and holds the grant for a whole message, delimited by req_last.
- Sequences the transmitter through a tx_start/tx_busy handshake.
- Sits between the client logic and the UART TX core, in the same baud_tick clock domain as the receiver.

Parameters:
- NREQ, 4, number of requesters (2..8).
- IDW, 3, width of the grant index; must satisfy 2**IDW >= NREQ.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  NREQ  requester i has a byte on its lane.
- req_data  in  8*NREQ  byte lanes; lane i is bits [8i+7:8i].
- req_last  in  NREQ  current byte is the last byte of requester i's message.
- req_ready  out  NREQ  one-hot, one-cycle pulse: lane i byte accepted this cycle.
- tx_start  out  1  one-cycle pulse; launches a UART frame.
- tx_data  out  8  byte to transmit; valid when tx_start=1.
- tx_busy  in  1  UART TX is shifting a frame.
- grant_id  out  IDW  index of the current owner.
- grant_active  out  1  a message is in progress.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, rr_ptr=0.
  - req_ready=0, tx_start=0, tx_data=0, grant_id=0, grant_active=0.
- Reset mid-message aborts the message with no further tx_start; any frame already on the line is the transmitter's concern.
- FSM states: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE.
- IDLE:
  - If any req_valid=1, pick the first asserted index searching rr_ptr, rr_ptr+1, ... modulo NREQ.
  - Latch it into grant_id, set grant_active=1, go to ISSUE.
  - Arbitration costs one cycle.
- ISSUE:
  - Waits for req_valid[grant_id]=1 and tx_busy=0.
  - When both hold, in the same cycle:
    - tx_start=1, tx_data=lane grant_id, req_ready[grant_id]=1.
    - Latch req_last[grant_id] into last_q.
  - Then go to WAIT_BUSY.
  - If the owner drops valid mid-message, stay in ISSUE; the grant is not revoked.
- WAIT_BUSY: wait for tx_busy=1, then go to WAIT_DONE. The TX core guarantees busy rises within 2 cycles of tx_start.
- WAIT_DONE: wait for tx_busy=0, then:
  - If last_q=1: rr_ptr = grant_id+1 (wraps to 0 when it reaches NREQ), grant_active=0, go to IDLE.
  - Else go to ISSUE for the next byte.
- Minimum byte spacing: ISSUE → WAIT_BUSY → WAIT_DONE → ISSUE, with no bubble beyond the transmitter's own busy time.
- Simultaneous requests are resolved by rr_ptr only; fixed priority never applies.
- Requests arriving while a grant is active are held pending. Their req_ready stays 0.
- NREQ=1 degenerates to pass-through with a one-cycle arbitration bubble per message.
- A single-byte message has req_last=1 on its first byte.
- req_data and req_last are sampled only in the ISSUE accept cycle.

Optional Feature:
- Macro: UART_ARB_ID_HDR_EN.
- When defined:
  - Each message is preceded by a header byte {4'hA, (4-IDW)'b0, grant_id}.
  - A HDR state is inserted between IDLE and ISSUE. It pulses tx_start with the header byte without pulsing req_ready, then waits for busy high and low exactly as WAIT_BUSY/WAIT_DONE do, and then enters ISSUE.
  - Requires IDW<=4.
- When undefined: no header byte and no HDR state; the behaviour is exactly as above.

Decomposition:
- Package uart_pkg holds:
  - FSM state encodings: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, HDR.
  - HDR_TAG=4'hA.
  - The default baud constants shared with the receiver and baud_tick.
- One sub-module: rr_pick. It is combinational; it takes req_valid and rr_ptr and outputs the winning index plus a found flag. It is reusable by other arbiters.

Test Plan:
1. Single requester: lane0 sends 0x55, 0x3C with last on 0x3C.
   - Expect exactly two tx_start pulses carrying 0x55 then 0x3C, and two req_ready[0] pulses.
   - grant_active drops after the second busy falls, and rr_ptr=1.
2. Contention: all four lanes valid at once with rr_ptr=0, each sending a 1-byte message (0x10, 0x11, 0x12, 0x13).
   - tx_data order is 0x10, 0x11, 0x12, 0x13; rr_ptr ends at 0.
3. Message lock: lane2 sends a 3-byte message and lane1 asserts valid after lane2's first byte.
   - All 3 lane2 bytes go out before any lane1 byte.
   - lane1 is granted next because the search starts at rr_ptr=3 and wraps to 1.
4. Owner stall: lane0 drops valid for 20 cycles between bytes while lane3 is requesting.
   - The grant stays on lane0, no tx_start occurs, and lane3 waits.
5. Async reset asserted in WAIT_DONE.
   - All outputs go to 0 immediately without waiting for a clock edge.
   - After release, the next arbitration starts from rr_ptr=0.
6. With UART_ARB_ID_HDR_EN: lane3 sends 0x7E.
   - tx_data sequence is 0xA3 then 0x7E, with a single req_ready[3] pulse on the 0x7E accept.
